// File: rtl/sync_ram_1w1r_pkg.sv
// ram_pkg: shared types, constants and helpers for sync_ram_1w1r (parity helper used when SYNC_RAM_PARITY_EN is defined)
package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

    // Even parity: the stored bit makes the total count of ones in byte+bit even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_ram_1w1r_if.sv
// sync_ram_1w1r_if: write/read request and response bundle; carries par_err when SYNC_RAM_PARITY_EN is defined
interface sync_ram_1w1r_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_be;
    logic                      rd_en;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_valid;
    logic                      busy;
`ifdef SYNC_RAM_PARITY_EN
    logic                      par_err;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
`ifdef SYNC_RAM_PARITY_EN
        input  par_err,
`endif
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
`ifdef SYNC_RAM_PARITY_EN
        output par_err,
`endif
        output rd_data, rd_valid, busy
    );

endinterface

// File: rtl/sync_ram_1w1r_clear_fsm.sv
// ram_clear_fsm: post-reset clear engine, walks addresses 0..LENGTH-1 once and then idles until the next reset
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LENGTH     = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_busy
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);

    clr_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;

    // One zero-write per cycle while clearing; leave CLEAR after the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == LAST) r_state <= IDLE;
        end
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_we   = o_busy;
    assign o_clr_addr = r_clr_addr;

endmodule

// File: rtl/sync_ram_1w1r.sv
// sync_ram_1w1r: 1W/1R synchronous RAM with byte enables, 1-2 cycle read latency, selectable
// read-during-write result and a post-reset clear engine; SYNC_RAM_PARITY_EN adds per-byte parity and par_err
module sync_ram_1w1r
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int LENGTH       = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = RDW_OLD
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_ram_1w1r_if.slave bus
);
    localparam int NB = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [LENGTH];
`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0]         r_par [LENGTH];
    logic [NB-1:0]         w_rd_perr;
    logic                  r_pe1;
`endif
    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NB-1:0]         w_wbe;
    logic                  w_rd_fire;
    logic                  w_rd_hit;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_rd_mem;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;

    ram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LENGTH     (LENGTH)
    ) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_busy     (w_busy)
    );

    // The clear engine owns the write port while busy; out-of-range user writes are dropped
    assign w_we    = w_busy ? w_clr_we : bus.wr_en && (int'(bus.wr_addr) < LENGTH);
    assign w_waddr = w_busy ? w_clr_addr : bus.wr_addr;
    assign w_wdata = w_busy ? '0 : bus.wr_data;
    assign w_wbe   = w_busy ? '1 : bus.wr_be;

    // Byte-lane write port shared by the clear engine and the user write
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_wbe[i]) begin
                    r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
                    r_par[w_waddr][i] <= even_parity(w_wdata[8*i +: 8]);
`endif
                end
            end
        end
    end

    assign w_rd_fire = bus.rd_en && !w_busy;
    assign w_rd_hit  = int'(bus.rd_addr) < LENGTH;
    assign w_bypass  = (RDW_MODE == RDW_NEW) && w_we && !w_busy && (bus.wr_addr == bus.rd_addr);
    assign w_rd_mem  = r_mem[bus.rd_addr];

    // Read word: zero when out of range, same-cycle write lanes forwarded in new-data mode
    always_comb begin
        w_rd_word = '0;
`ifdef SYNC_RAM_PARITY_EN
        w_rd_perr = '0;
`endif
        for (int i = 0; i < NB; i++) begin
            w_rd_word[8*i +: 8] = !w_rd_hit ? 8'h00 :
                                  (w_bypass && bus.wr_be[i]) ? bus.wr_data[8*i +: 8] : w_rd_mem[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
            w_rd_perr[i] = w_rd_hit && !(w_bypass && bus.wr_be[i]) &&
                           (r_par[bus.rd_addr][i] != even_parity(w_rd_mem[8*i +: 8]));
`endif
        end
    end

    // First read stage: valid pulse per accepted read, data held between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_d1  <= '0;
`ifdef SYNC_RAM_PARITY_EN
            r_pe1 <= 1'b0;
`endif
        end else begin
            r_v1  <= w_rd_fire;
            if (w_rd_fire) r_d1 <= w_rd_word;
`ifdef SYNC_RAM_PARITY_EN
            r_pe1 <= w_rd_fire && |w_rd_perr;
`endif
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_d2;
`ifdef SYNC_RAM_PARITY_EN
            logic                  r_pe2;
`endif
            // Optional output register stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2  <= 1'b0;
                    r_d2  <= '0;
`ifdef SYNC_RAM_PARITY_EN
                    r_pe2 <= 1'b0;
`endif
                end else begin
                    r_v2  <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
`ifdef SYNC_RAM_PARITY_EN
                    r_pe2 <= r_pe1;
`endif
                end
            end
            assign bus.rd_valid = r_v2;
            assign bus.rd_data  = r_d2;
`ifdef SYNC_RAM_PARITY_EN
            assign bus.par_err  = r_pe2;
`endif
        end else begin : g_lat1
            assign bus.rd_valid = r_v1;
            assign bus.rd_data  = r_d1;
`ifdef SYNC_RAM_PARITY_EN
            assign bus.par_err  = r_pe1;
`endif
        end
    endgenerate

    assign bus.busy = w_busy;

endmodule

// File: tb/tb_sync_ram_1w1r.sv
// tb_sync_ram_1w1r: two configurations (16 words/latency 1/old-data and 12 of 16 words/latency 2/new-data)
// driven by the same stimulus and checked against a word-level memory model; SYNC_RAM_PARITY_EN enables parity checks
module tb_sync_ram_1w1r;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_ram_1w1r_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b0 ();
    sync_ram_1w1r_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b1 ();

    sync_ram_1w1r #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LENGTH(16), .READ_LATENCY(1), .RDW_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    sync_ram_1w1r #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LENGTH(12), .READ_LATENCY(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        pe;
    } rd_t;

    rd_t         rq [2][$];
    logic [31:0] mm [2][16];
    logic [3:0]  bad [2][16];
    int          clr_left [2];
    logic [31:0] last [2];
    int          edge_n = 0;

    logic [31:0] seen [3];
    int          at [3];
    int          n_seen;

    function automatic int len(input int d);
        return d == 0 ? 16 : 12;
    endfunction

    function automatic int rl(input int d);
        return d == 0 ? 1 : 2;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: one clock edge of the memory as seen through the ports
    task automatic model_edge(input int d);
        rd_t         e;
        logic [3:0]  lanes;
        logic        hit;
        if (!rst_n) begin
            clr_left[d] = len(d);
            rq[d].delete();
            last[d] = '0;
            for (int a = 0; a < 16; a++) begin
                mm[d][a] = '0;
                bad[d][a] = '0;
            end
            return;
        end
        if (clr_left[d] > 0) begin
            clr_left[d]--;
            return;
        end
        if (b0.rd_en) begin
            lanes = (d == 1 && b0.wr_en && b0.wr_addr == b0.rd_addr) ? b0.wr_be : 4'h0;
            hit   = int'(b0.rd_addr) < len(d);
            e.due = edge_n + rl(d) - 1;
            e.d   = hit ? merge(mm[d][b0.rd_addr], b0.wr_data, lanes) : 32'h0;
            e.pe  = hit && |(bad[d][b0.rd_addr] & ~lanes);
            rq[d].push_back(e);
        end
        if (b0.wr_en && int'(b0.wr_addr) < len(d)) begin
            mm[d][b0.wr_addr]  = merge(mm[d][b0.wr_addr], b0.wr_data, b0.wr_be);
            bad[d][b0.wr_addr] = bad[d][b0.wr_addr] & ~b0.wr_be;
        end
    endtask

    task automatic compare(input int d);
        logic ev;
        logic epe;
        ev  = 1'b0;
        epe = 1'b0;
        if (rq[d].size() > 0) begin
            if (rq[d][0].due == edge_n) begin
                ev      = 1'b1;
                last[d] = rq[d][0].d;
                epe     = rq[d][0].pe;
                void'(rq[d].pop_front());
            end
        end
        chk($sformatf("busy%0d", d), d == 0 ? b0.busy : b1.busy, clr_left[d] > 0);
        chk($sformatf("rd_valid%0d", d), d == 0 ? b0.rd_valid : b1.rd_valid, ev);
        chk($sformatf("rd_data%0d", d), d == 0 ? b0.rd_data : b1.rd_data, last[d]);
`ifdef SYNC_RAM_PARITY_EN
        chk($sformatf("par_err%0d", d), d == 0 ? b0.par_err : b1.par_err, epe);
`else
        if (epe) chk($sformatf("no_parity%0d", d), epe, 1'b0);
`endif
    endtask

    always @(posedge clk) begin
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        compare(0);
        compare(1);
    end

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be,
                         input logic re, input logic [3:0] ra);
        b0.wr_en = we; b0.wr_addr = wa; b0.wr_data = wd; b0.wr_be = be; b0.rd_en = re; b0.rd_addr = ra;
        b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd; b1.wr_be = be; b1.rd_en = re; b1.rd_addr = ra;
    endtask

    task automatic drive_idle();
        drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic drive_rand();
        logic [3:0] wa;
        wa = 4'($urandom);
        drive(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom),
              ($urandom_range(3) == 0) ? wa : 4'($urandom));
    endtask

    // One request cycle, then watch both instances for their read result and its latency
    task automatic txn(input string nm, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra,
                       input logic [31:0] e0, input logic [31:0] e1, input logic pe0, input logic pe1);
        logic got0;
        logic got1;
        got0 = 1'b0;
        got1 = 1'b0;
        @(negedge clk);
        drive(we, wa, wd, be, re, ra);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #2;
            if (k == 1) drive_idle();
            if (b0.rd_valid) begin
                got0 = 1'b1;
                chk({nm, "_lat0"}, k, 1);
                chk({nm, "_data0"}, b0.rd_data, e0);
`ifdef SYNC_RAM_PARITY_EN
                chk({nm, "_pe0"}, b0.par_err, pe0);
`endif
            end
            if (b1.rd_valid) begin
                got1 = 1'b1;
                chk({nm, "_lat1"}, k, 2);
                chk({nm, "_data1"}, b1.rd_data, e1);
`ifdef SYNC_RAM_PARITY_EN
                chk({nm, "_pe1"}, b1.par_err, pe1);
`endif
            end
        end
        chk({nm, "_valid0"}, got0, re);
        chk({nm, "_valid1"}, got1, re);
    endtask

    task automatic wr(input string nm, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
        txn(nm, 1'b1, wa, wd, be, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string nm, input logic [3:0] ra, input logic [31:0] e0, input logic [31:0] e1);
        txn(nm, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, ra, e0, e1, 1'b0, 1'b0);
    endtask

    // Starting at the release edge, count busy cycles while pulsing requests into the clear window
    task automatic busy_count(input string nm);
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 30; k++) begin
            n0 += int'(b0.busy);
            n1 += int'(b1.busy);
            if (b1.busy) drive_rand();
            else drive_idle();
            @(negedge clk);
        end
        chk({nm, "_busy_len0"}, n0, 16);
        chk({nm, "_busy_len1"}, n1, 12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    initial begin
        drive_idle();
        repeat (3) @(negedge clk);
        chk("rst_busy0", b0.busy, 1'b1);
        chk("rst_valid1", b1.rd_valid, 1'b0);
        chk("rst_data1", b1.rd_data, 32'h0);
        rst_n = 1'b1;
        busy_count("clr");

        for (int a = 0; a < 16; a++) rd($sformatf("zero%0d", a), 4'(a), 32'h0, 32'h0);

        wr("w_dead", 4'd3, 32'hDEADBEEF, 4'b1111);
        wr("w_aa", 4'd3, 32'h000000AA, 4'b0001);
        rd("r_beaa", 4'd3, 32'hDEADBEAA, 32'hDEADBEAA);

        txn("rdw", 1'b1, 4'd5, 32'h12345678, 4'b1111, 1'b1, 4'd5, 32'h00000000, 32'h12345678, 1'b0, 1'b0);
        rd("r_after_rdw", 4'd5, 32'h12345678, 32'h12345678);

        wr("w0", 4'd0, 32'h11111111, 4'hF);
        wr("w1", 4'd1, 32'h22222222, 4'hF);
        wr("w2", 4'd2, 32'h33333333, 4'hF);
        n_seen = 0;
        fork
            begin
                @(negedge clk); drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd0);
                @(negedge clk); drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd1);
                @(negedge clk); drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd2);
                @(negedge clk); drive_idle();
            end
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk);
                #2;
                if (b1.rd_valid && n_seen < 3) begin
                    seen[n_seen] = b1.rd_data;
                    at[n_seen] = k;
                    n_seen++;
                end
            end
        join
        chk("burst_count", n_seen, 3);
        chk("burst_at0", at[0], 2);
        chk("burst_at2", at[2], 4);
        chk("burst_d0", seen[0], 32'h11111111);
        chk("burst_d1", seen[1], 32'h22222222);
        chk("burst_d2", seen[2], 32'h33333333);

        wr("w_oor", 4'd13, 32'hCAFEF00D, 4'hF);
        rd("r_oor", 4'd13, 32'hCAFEF00D, 32'h0);
        wr("w_be0", 4'd3, 32'hFFFFFFFF, 4'h0);
        rd("r_be0", 4'd3, 32'hDEADBEAA, 32'hDEADBEAA);

`ifdef SYNC_RAM_PARITY_EN
        wr("w_par", 4'd9, 32'h0F0F0F0F, 4'hF);
        @(negedge clk);
        u0.r_mem[9][0] = ~u0.r_mem[9][0];
        u1.r_mem[9][0] = ~u1.r_mem[9][0];
        for (int d = 0; d < 2; d++) begin
            mm[d][9][0] = ~mm[d][9][0];
            bad[d][9][0] = 1'b1;
        end
        txn("par_bad", 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd9, 32'h0F0F0F0E, 32'h0F0F0F0E, 1'b1, 1'b1);
        txn("par_ok", 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            drive_rand();
        end
        @(negedge clk);
        drive_idle();
        repeat (4) @(negedge clk);

        wr("w_pre", 4'd2, 32'h5A5A5A5A, 4'hF);
        rd("r_pre", 4'd2, 32'h5A5A5A5A, 32'h5A5A5A5A);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_data0", b0.rd_data, 32'h0);
        chk("async_data1", b1.rd_data, 32'h0);
        chk("async_busy1", b1.busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive_rand();
            @(negedge clk);
        end
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy_count("restart");
        rd("r_cleared", 4'd2, 32'h0, 32'h0);
        rd("r_cleared3", 4'd3, 32'h0, 32'h0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
